gpu_data_mem: RTL and testbench

Parametrised, multi-lane data memory for the GPU core. It replaces the single-port, combinational-read data memory. Up to `NUM_LANES` requesters share one synchronous-read storage array through a valid/ready handshake and a round-robin arbiter. Storage is zeroed by a hardware sweep after every reset, and completion is signalled on `init_done`.

---
 rtl/gpu_data_mem_pkg.sv | 20 ++
 rtl/gpu_data_mem_if.sv | 26 ++
 rtl/gpu_data_mem_rr_arbiter.sv | 46 ++++
 rtl/gpu_data_mem.sv | 90 +++++++++
 tb/tb_gpu_data_mem.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/gpu_data_mem_pkg.sv
// Shared types and default widths for the multi-lane GPU data memory.
// Imported by the memory top, its arbiter and the bench.
package gpu_mem_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_NUM_LANES  = 4;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic                      write;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/gpu_data_mem_if.sv
// Lane request/response bundle between requesters (master) and the data memory (slave).
// Lane i of the flattened address/data buses sits at [i*W +: W].
interface gpu_data_mem_if #(
    parameter int NUM_LANES  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic [NUM_LANES-1:0]            req_valid;
    logic [NUM_LANES-1:0]            req_write;
    logic [NUM_LANES*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_LANES*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_LANES-1:0]            req_ready;
    logic [NUM_LANES-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]           resp_rdata;
    logic                            init_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, init_done
    );
endinterface

// File: rtl/gpu_data_mem_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at rr_ptr and wraps.
// Pointer advances past the winner only when enabled and some request is present.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] rr_ptr;
    logic          found;

    always_comb begin
        int            j;
        logic [IW-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N) j = j - N;
            idx = IW'(j);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (en && found) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (en && found) begin
            rr_ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/gpu_data_mem.sv
// Multi-lane data memory: zero sweep after reset, then one arbitrated access per cycle.
// Read data and completion strobe one cycle after acceptance; unselected lanes simply wait.
module gpu_data_mem
    import gpu_mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_LANES  = DEF_NUM_LANES
) (
    input  logic           clk,
    input  logic           reset,
    gpu_data_mem_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int IW    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    mem_state_e            state;
    mem_state_e            state_nxt;
    logic                  serving;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [NUM_LANES-1:0]  gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  accept;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [NUM_LANES-1:0]  resp_valid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_nxt = state;
        serving   = 1'b0;
        case (state)
            CLEAR: if (clr_ptr == '1) state_nxt = SERVE;
            SERVE: serving = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    rr_arbiter #(.N(NUM_LANES)) u_arb (
        .clk     (clk),
        .rst     (reset),
        .req     (bus.req_valid),
        .en      (serving),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The grant is already qualified by req_valid, so any grant is an acceptance.
    assign accept    = |gnt;
    assign sel_write = bus.req_write[gnt_idx];
    assign sel_addr  = bus.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = bus.req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (accept && sel_write) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid_q <= '0;
            rdata_q      <= '0;
        end else begin
            resp_valid_q <= gnt;
            if (accept && !sel_write) rdata_q <= mem[sel_addr];
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.init_done  = (state == SERVE);

endmodule

// File: tb/tb_gpu_data_mem.sv
// Directed bench for gpu_data_mem: sweep timing, read/write, round robin, reset recovery, contention.
`timescale 1ns/1ps
module tb_gpu_data_mem;
    import gpu_mem_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    gpu_data_mem_if #(.NUM_LANES(4), .ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    gpu_data_mem #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .NUM_LANES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Counts edges from reset release until init_done; flags any grant or response meanwhile.
    task automatic wait_init(output int cycles, output logic leak);
        cycles = 0;
        leak   = 1'b0;
        while (cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (bus.init_done) break;
            if (bus.req_ready != 4'b0 || bus.resp_valid != 4'b0) leak = 1'b1;
        end
    endtask

    // Presents one request at a negedge and returns at the negedge after it is accepted.
    task automatic issue(input int lane, input logic wr, input logic [7:0] a, input logic [15:0] d);
        int n;
        bus.req_write[lane]          = wr;
        bus.req_addr[lane*8 +: 8]    = a;
        bus.req_wdata[lane*16 +: 16] = d;
        bus.req_valid[lane]          = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[lane] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("issue_ready", {31'b0, bus.req_ready[lane]}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[lane] = 1'b0;
    endtask

    initial begin
        mem_req_t   seed [3];
        int         cyc;
        logic       leak;
        logic [3:0] g;
        logic [3:0] prev_g;
        logic       prev_rd;
        logic [15:0] prev_exp;
        logic [15:0] last_val;
        int         k1, k3, w1, w3, max1, max3;

        n_checks = 0;
        n_pass   = 0;
        seed[0] = '{write: 1'b1, addr: 8'h00, wdata: 16'h1111};
        seed[1] = '{write: 1'b1, addr: 8'h80, wdata: 16'h2222};
        seed[2] = '{write: 1'b1, addr: 8'hFF, wdata: 16'h3333};

        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        reset = 1'b1;
        #8;
        check("rst_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_rdata", bus.resp_rdata, 0);
        check("rst_init_done", bus.init_done, 0);
        @(negedge clk);
        reset = 1'b0;

        wait_init(cyc, leak);
        check("sweep1_cycles", cyc, 256);
        check("sweep1_quiet", leak, 0);

        // Round robin from rr_ptr = 0 with all four lanes requesting.
        bus.req_write = 4'b0000;
        bus.req_addr  = {8'h03, 8'h02, 8'h01, 8'h00};
        bus.req_valid = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            #1;
            check("rr_grant", bus.req_ready, 32'd1 << (j % 4));
            if (j > 0) check("rr_resp", bus.resp_valid, 32'd1 << ((j - 1) % 4));
            @(negedge clk);
        end
        check("rr_resp_last", bus.resp_valid, 32'd1);
        bus.req_valid = 4'b0000;

        for (int s = 0; s < 3; s++) issue(0, seed[s].write, seed[s].addr, seed[s].wdata);
        issue(0, 1'b0, 8'h80, 16'h0);
        check("seed_readback", bus.resp_rdata, 16'h2222);

        issue(0, 1'b1, 8'hA5, 16'hBEEF);
        check("wr_resp_valid", bus.resp_valid, 4'b0001);
        issue(0, 1'b0, 8'hA5, 16'h0);
        check("rd_resp_valid", bus.resp_valid, 4'b0001);
        check("rd_rdata", bus.resp_rdata, 16'hBEEF);
        @(negedge clk);
        check("idle_resp_valid", bus.resp_valid, 0);
        check("idle_rdata_hold", bus.resp_rdata, 16'hBEEF);

        // Lane 1 read in flight, then a half-cycle reset; lane 2 waits through the sweep.
        bus.req_write[1]     = 1'b0;
        bus.req_addr[8 +: 8] = 8'h80;
        bus.req_valid[1]     = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        bus.req_valid = 4'b0000;
        #1;
        check("midrst_resp_valid", bus.resp_valid, 0);
        check("midrst_init_done", bus.init_done, 0);
        check("midrst_rdata", bus.resp_rdata, 0);
        bus.req_write[2]      = 1'b0;
        bus.req_addr[16 +: 8] = 8'h00;
        bus.req_valid[2]      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_init(cyc, leak);
        check("sweep2_cycles", cyc, 256);
        check("sweep2_quiet", leak, 0);
        #1;
        check("lane2_first_grant", bus.req_ready, 4'b0100);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        check("lane2_resp_valid", bus.resp_valid, 4'b0100);
        check("clr_addr0", bus.resp_rdata, 0);
        issue(0, 1'b0, 8'h80, 16'h0);
        check("clr_addr128", bus.resp_rdata, 0);
        issue(0, 1'b0, 8'hFF, 16'h0);
        check("clr_addr255", bus.resp_rdata, 0);

        // Lanes 1 and 3 contend on address 0x10, each alternating write then read.
        k1 = 0; k3 = 0; w1 = 0; w3 = 0; max1 = 0; max3 = 0;
        last_val = 16'h0000;
        prev_g   = 4'b0;
        prev_rd  = 1'b0;
        prev_exp = 16'h0;
        for (int c = 0; c < 16; c++) begin
            if (c > 0) begin
                check("ctn_resp_valid", bus.resp_valid, prev_g);
                if (prev_rd) check("ctn_rdata", bus.resp_rdata, prev_exp);
            end
            bus.req_write[1]       = (k1 % 2 == 0);
            bus.req_addr[8 +: 8]   = 8'h10;
            bus.req_wdata[16 +: 16] = 16'h1000 + 16'(k1);
            bus.req_write[3]       = (k3 % 2 == 0);
            bus.req_addr[24 +: 8]  = 8'h10;
            bus.req_wdata[48 +: 16] = 16'h3000 + 16'(k3);
            bus.req_valid          = 4'b1010;
            #1;
            g = bus.req_ready;
            check("ctn_onehot", {31'b0, (g == 4'b0010 || g == 4'b1000)}, 32'd1);
            prev_g  = g;
            prev_rd = 1'b0;
            if (g[1]) begin
                if (k1 % 2 == 0) last_val = 16'h1000 + 16'(k1);
                else begin prev_rd = 1'b1; prev_exp = last_val; end
                k1++;
                w1 = 0;
            end else begin
                w1++;
                if (w1 > max1) max1 = w1;
            end
            if (g[3]) begin
                if (k3 % 2 == 0) last_val = 16'h3000 + 16'(k3);
                else begin prev_rd = 1'b1; prev_exp = last_val; end
                k3++;
                w3 = 0;
            end else begin
                w3++;
                if (w3 > max3) max3 = w3;
            end
            @(negedge clk);
        end
        bus.req_valid = 4'b0000;
        check("ctn_resp_valid_last", bus.resp_valid, prev_g);
        if (prev_rd) check("ctn_rdata_last", bus.resp_rdata, prev_exp);
        check("ctn_wait_lane1", {31'b0, (max1 <= 4)}, 32'd1);
        check("ctn_wait_lane3", {31'b0, (max3 <= 4)}, 32'd1);
        check("ctn_progress", {31'b0, (k1 >= 4 && k3 >= 4)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
